// File: rtl/lfsr_victim_sel_if.sv
// Request/result bundle for the LFSR victim selector; clock and reset stay plain ports.
interface lfsr_victim_sel_if #(
  parameter int LfsrWidth = 8,
  parameter int NumWays   = 8
);
  localparam int BinW = (NumWays > 1) ? $clog2(NumWays) : 1;

  logic                 seed_load_i;
  logic [LfsrWidth-1:0] seed_i;
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [NumWays-1:0]   way_valid_i;
  logic                 victim_valid_o;
  logic                 victim_ack_i;
  logic [NumWays-1:0]   victim_oh_o;
  logic [BinW-1:0]      victim_bin_o;
  logic [LfsrWidth-1:0] lfsr_o;

  modport master (
    output seed_load_i, seed_i, req_valid_i, way_valid_i, victim_ack_i,
    input  req_ready_o, victim_valid_o, victim_oh_o, victim_bin_o, lfsr_o
  );

  modport slave (
    input  seed_load_i, seed_i, req_valid_i, way_valid_i, victim_ack_i,
    output req_ready_o, victim_valid_o, victim_oh_o, victim_bin_o, lfsr_o
  );
endinterface

// File: rtl/lfsr_victim_sel.sv
// Cache victim selector: first free way, else a pseudo-random way from a Fibonacci LFSR.
// Optional macro LFSR_VICTIM_SEL_LOCKUP_RECOVERY_EN forces the all-zero LFSR state back to Seed.
module lfsr_victim_sel #(
  parameter int                   LfsrWidth = 8,
  parameter logic [LfsrWidth-1:0] Seed      = 'h1,
  parameter int                   NumWays   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  lfsr_victim_sel_if.slave  bus
);
  localparam int BinW = (NumWays > 1) ? $clog2(NumWays) : 1;

  // Feedback bit mask: bit (tap-1) set for each maximal-length tap.
  function automatic logic [LfsrWidth-1:0] tap_mask(input int w);
    logic [15:0] m;
    case (w)
      3:       m = 16'h0006;
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h0000;
    endcase
    return m[LfsrWidth-1:0];
  endfunction

  localparam logic [LfsrWidth-1:0] TapMask = tap_mask(LfsrWidth);

  logic [LfsrWidth-1:0] state_q, state_d;
  logic                 vld_q, vld_d;
  logic [NumWays-1:0]   oh_q, oh_d;
  logic [BinW-1:0]      bin_q, bin_d;

  logic                 ready;
  logic                 accept;
  logic                 fb;
  logic [BinW-1:0]      lfsr_idx;
  logic [BinW-1:0]      free_idx;
  logic                 free_found;
  logic [BinW-1:0]      victim_idx;

  always_comb begin
    ready  = !vld_q || bus.victim_ack_i;
    accept = bus.req_valid_i && ready;
    fb     = ^(state_q & TapMask);

    // Low LFSR bits fold back into range when NumWays is not a power of two.
    lfsr_idx = state_q[BinW-1:0];
    if ({1'b0, lfsr_idx} >= (BinW+1)'(NumWays)) begin
      lfsr_idx = lfsr_idx - BinW'(NumWays);
    end

    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NumWays - 1; i >= 0; i--) begin
      if (!bus.way_valid_i[i]) begin
        free_found = 1'b1;
        free_idx   = BinW'(i);
      end
    end
    victim_idx = free_found ? free_idx : lfsr_idx;

    state_d = state_q;
    if (accept) begin
      state_d = {state_q[LfsrWidth-2:0], fb};
    end
`ifdef LFSR_VICTIM_SEL_LOCKUP_RECOVERY_EN
    if (state_q == '0) begin
      state_d = Seed;
    end
    if (bus.seed_load_i) begin
      state_d = (bus.seed_i == '0) ? Seed : bus.seed_i;
    end
`else
    if (bus.seed_load_i) begin
      state_d = bus.seed_i;
    end
`endif

    vld_d = vld_q;
    oh_d  = oh_q;
    bin_d = bin_q;
    if (accept) begin
      vld_d = 1'b1;
      oh_d  = NumWays'(1) << victim_idx;
      bin_d = victim_idx;
    end else if (bus.victim_ack_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Seed;
      vld_q   <= 1'b0;
      oh_q    <= '0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      oh_q    <= oh_d;
      bin_q   <= bin_d;
    end
  end

  assign bus.req_ready_o    = ready;
  assign bus.victim_valid_o = vld_q;
  assign bus.victim_oh_o    = oh_q;
  assign bus.victim_bin_o   = bin_q;
  assign bus.lfsr_o         = state_q;
endmodule

// File: tb/tb_lfsr_victim_sel.sv
// Randomized self-checking bench for lfsr_victim_sel against a behavioural victim-selection model.
module tb_lfsr_victim_sel;
  localparam int W    = 8;
  localparam int SEED = 1;
  localparam int N    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lfsr_victim_sel_if #(.LfsrWidth(W), .NumWays(N)) bus ();
  lfsr_victim_sel_if #(.LfsrWidth(W), .NumWays(6)) bus6 ();

  lfsr_victim_sel #(.LfsrWidth(W), .Seed(8'h01), .NumWays(N)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave)
  );
  lfsr_victim_sel #(.LfsrWidth(W), .Seed(8'h01), .NumWays(6)) dut6 (
    .clk_i(clk), .rst_i(rst), .bus(bus6.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int m_state, m_vld, m_oh, m_bin;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int lfsr_next(input int s);
    int taps[4] = '{8, 6, 5, 4};
    int fb = 0;
    foreach (taps[k]) fb ^= (s >> (taps[k] - 1)) & 1;
    return ((s << 1) | fb) & 'hFF;
  endfunction

  function automatic int pick_ref(input int s, input int n, input int wv);
    int span, idx;
    for (int i = 0; i < n; i++) if (((wv >> i) & 1) == 0) return i;
    span = 1 << $clog2(n);
    idx  = s % span;
    if (idx >= n) idx -= n;
    return idx;
  endfunction

  // One clock: advance the model from the inputs now applied, then compare after the edge.
  task automatic cycle();
    bit acc;
    int nxt, v;
    if (rst) begin
      m_state = SEED; m_vld = 0; m_oh = 0; m_bin = 0;
    end else begin
      acc = bus.req_valid_i && (m_vld == 0 || bus.victim_ack_i);
      nxt = m_state;
      if (acc) begin
        v = pick_ref(m_state, N, int'(bus.way_valid_i));
        m_bin = v;
        m_oh  = 1 << v;
        nxt   = lfsr_next(m_state);
      end
`ifdef LFSR_VICTIM_SEL_LOCKUP_RECOVERY_EN
      if (m_state == 0) nxt = SEED;
      if (bus.seed_load_i) nxt = (bus.seed_i == 0) ? SEED : int'(bus.seed_i);
`else
      if (bus.seed_load_i) nxt = int'(bus.seed_i);
`endif
      m_state = nxt;
      if (acc) m_vld = 1;
      else if (bus.victim_ack_i) m_vld = 0;
    end
    @(posedge clk);
    #1;
    chk("lfsr",  bus.lfsr_o,         m_state);
    chk("vld",   bus.victim_valid_o, m_vld);
    chk("bin",   bus.victim_bin_o,   m_bin);
    chk("oh",    bus.victim_oh_o,    m_oh);
    chk("ready", bus.req_ready_o,    (m_vld == 0 || bus.victim_ack_i) ? 1 : 0);
  endtask

  task automatic idle();
    bus.seed_load_i = 1'b0; bus.seed_i = '0; bus.req_valid_i = 1'b0;
    bus.victim_ack_i = 1'b0; bus.way_valid_i = '1;
  endtask

  initial begin
    int first_ret;
    int exp_lfsr[4] = '{'h02, 'h04, 'h08, 'h11};
    int exp_bin[4]  = '{1, 2, 4, 0};

    idle();
    bus6.seed_load_i = 1'b0; bus6.seed_i = '0; bus6.req_valid_i = 1'b0;
    bus6.victim_ack_i = 1'b0; bus6.way_valid_i = '1;

    // Reset state
    rst = 1'b1;
    cycle(); cycle();
    chk("rst_ready_during", bus.req_ready_o, 1);
    chk("rst_lfsr", bus.lfsr_o, 8'h01);
    rst = 1'b0;
    cycle();
    chk("rst_ready_after", bus.req_ready_o, 1);

    // Six-way instance: out-of-range LFSR index folds to way 0
    bus6.seed_load_i = 1'b1; bus6.seed_i = 8'h0E;
    cycle();
    chk("w6_seed", bus6.lfsr_o, 8'h0E);
    bus6.seed_load_i = 1'b0; bus6.req_valid_i = 1'b1;
    cycle();
    bus6.req_valid_i = 1'b0;
    chk("w6_vld", bus6.victim_valid_o, 1);
    chk("w6_bin", bus6.victim_bin_o, 0);
    chk("w6_oh",  bus6.victim_oh_o, 6'b000001);
    chk("w6_lfsr_adv", bus6.lfsr_o, lfsr_next('h0E));

    // Back-to-back ack+request, all ways occupied
    bus.req_valid_i = 1'b1; bus.victim_ack_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("b2b_lfsr", bus.lfsr_o, exp_lfsr[k]);
      chk("b2b_bin",  bus.victim_bin_o, exp_bin[k]);
      chk("b2b_vld",  bus.victim_valid_o, 1);
    end

    // Free way wins; LFSR still advances once
    bus.way_valid_i = 8'b1111_0111;
    cycle();
    chk("free_bin", bus.victim_bin_o, 3);
    chk("free_lfsr", bus.lfsr_o, lfsr_next('h11));
    bus.way_valid_i = '1;

    // Held result without ack blocks new requests
    bus.victim_ack_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("hold_ready", bus.req_ready_o, 0);
      chk("hold_bin", bus.victim_bin_o, 3);
    end
    bus.victim_ack_i = 1'b1; bus.req_valid_i = 1'b0;
    cycle();
    chk("ack_clear", bus.victim_valid_o, 0);
    chk("ack_bin_hold", bus.victim_bin_o, 3);

    // Full period from Seed
    rst = 1'b1; idle(); cycle(); rst = 1'b0;
    bus.req_valid_i = 1'b1; bus.victim_ack_i = 1'b1;
    first_ret = 0;
    for (int k = 1; k <= 255; k++) begin
      cycle();
      if (bus.lfsr_o == 8'h00) chk("period_zero", bus.lfsr_o, 1);
      if (bus.lfsr_o == 8'h01 && first_ret == 0) first_ret = k;
    end
    chk("period_len", first_ret, 255);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      bus.req_valid_i  = ($urandom_range(0, 3) != 0);
      bus.victim_ack_i = ($urandom_range(0, 2) != 0);
      bus.way_valid_i  = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      bus.seed_load_i  = ($urandom_range(0, 15) == 0);
      bus.seed_i       = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      cycle();
    end

    // Zero seed load, then reset while a result is held
    idle();
    bus.seed_load_i = 1'b1; bus.seed_i = 8'h00;
    cycle();
    bus.seed_load_i = 1'b0;
`ifdef LFSR_VICTIM_SEL_LOCKUP_RECOVERY_EN
    chk("zero_seed", bus.lfsr_o, 8'h01);
`else
    chk("zero_seed", bus.lfsr_o, 8'h00);
`endif
    bus.req_valid_i = 1'b1; bus.victim_ack_i = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
`ifndef LFSR_VICTIM_SEL_LOCKUP_RECOVERY_EN
    chk("zero_persist", bus.lfsr_o, 8'h00);
    chk("zero_pick", bus.victim_bin_o, 0);
`endif
    bus.victim_ack_i = 1'b0;
    cycle();
    bus.req_valid_i = 1'b0;
    cycle();
    chk("pre_rst_vld", bus.victim_valid_o, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_vld", bus.victim_valid_o, 0);
    chk("mid_rst_lfsr", bus.lfsr_o, 8'h01);
    chk("mid_rst_ready", bus.req_ready_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lfsr_victim_sel.md
LFSR_VICTIM_SEL -- requirements
Module: lfsr_victim_sel

Interface
REQ-001 SHALL have parameter LfsrWidth, default 8, LFSR state width; legal range 3..16.
REQ-002 SHALL have parameter Seed, default 'h1, LFSR reset/recovery value; must be nonzero.
REQ-003 SHALL have parameter NumWays, default 8, candidate way count; legal range 2..2**LfsrWidth, any value (not only powers of two).
REQ-004 SHALL have clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have rst_i  input  1  reset, synchronous and active-high.
REQ-006 SHALL have seed_load_i  input  1  load seed_i into LFSR.
REQ-007 SHALL have seed_i  input  LfsrWidth  seed value.
REQ-008 SHALL have req_valid_i  input  1  victim request.
REQ-009 SHALL have req_ready_o  output  1  request accepted when high with req_valid_i.
REQ-010 SHALL have way_valid_i  input  NumWays  per-way occupied flags, sampled on acceptance.
REQ-011 SHALL have victim_valid_o  output  1  victim result held.
REQ-012 SHALL have victim_ack_i  input  1  consumer takes result.
REQ-013 SHALL have victim_oh_o  output  NumWays  one-hot victim.
REQ-014 SHALL have victim_bin_o  output  max(1,$clog2(NumWays))  binary victim index.
REQ-015 SHALL have lfsr_o  output  LfsrWidth  current LFSR state.

Function
REQ-016 SHALL be a Fibonacci XOR LFSR: state_d = {state_q[W-2:0], fb}, fb = XOR of state_q bits (tap-1) for the maximal-length taps: 3:{3,2} 4:{4,3} 5:{5,3} 6:{6,5} 7:{7,6} 8:{8,6,5,4} 9:{9,5} 10:{10,7} 11:{11,9} 12:{12,6,4,1} 13:{13,4,3,1} 14:{14,5,3,1} 15:{15,14} 16:{16,15,13,4}.
REQ-017 SHALL accept a request when req_valid_i && req_ready_o; req_ready_o = !victim_valid_o || victim_ack_i (combinational).
REQ-018 SHALL advance the LFSR exactly once per accepted request and hold it otherwise.
REQ-019 SHALL, on acceptance, choose the lowest-index way with way_valid_i=0 if any exists; else the LFSR pick.
REQ-020 SHALL compute LFSR pick from pre-advance state_q: idx = state_q[L-1:0], L=$clog2(NumWays); if idx >= NumWays, pick = idx - NumWays.
REQ-021 SHALL register the victim: victim_valid_o, victim_oh_o, victim_bin_o update the cycle after acceptance (latency 1) and hold stable until acked.
REQ-022 SHALL, on ack without new acceptance, clear victim_valid_o next cycle; oh/bin outputs hold last value.
REQ-023 SHALL, on ack and acceptance in the same cycle, present the new victim next cycle with victim_valid_o staying 1.
REQ-024 SHALL give seed_load_i priority over advance: state_d = seed_i; a request accepted that cycle still uses pre-load state_q for its pick.
REQ-025 SHALL drive lfsr_o = state_q.

Reset
REQ-026 SHALL, when rst_i is high at a clock edge, set state_q=Seed, victim_valid_o=0, victim_oh_o=0, victim_bin_o=0; rst_i overrides seed_load_i and requests.
REQ-027 SHALL hold req_ready_o=1 during and after reset until a result is held.

Configuration
REQ-028 SHALL honour macro LFSR_VICTIM_SEL_LOCKUP_RECOVERY_EN: when defined, any cycle with state_q==0 forces state_d=Seed (over advance), and seed_load_i with seed_i==0 loads Seed.
REQ-029 SHALL, without LFSR_VICTIM_SEL_LOCKUP_RECOVERY_EN, load seed_i==0 verbatim, after which the all-zero state persists and all LFSR picks are way 0.

Verification
REQ-030 SHALL cover: W=8, Seed=0x01, four back-to-back acks+requests, all ways valid -> lfsr_o 0x01,0x02,0x04,0x08,0x11; victim_bin_o 1,2,4,0.
REQ-031 SHALL cover: W=8, free-run 255 accepted requests -> lfsr_o returns to 0x01 only at request 255, never 0x00.
REQ-032 SHALL cover: NumWays=6, seed_load 0x0E, one request, all valid -> victim_bin_o=0, victim_oh_o=6'b000001.
REQ-033 SHALL cover: way_valid_i=8'b1111_0111 -> victim_bin_o=3, LFSR still advances once.
REQ-034 SHALL cover: victim held, victim_ack_i=0 for 5 cycles with req_valid_i=1 -> req_ready_o=0, outputs stable, lfsr_o unchanged.
REQ-035 SHALL cover: seed_load_i with seed_i=0 -> with macro lfsr_o=Seed next cycle; without macro lfsr_o=0 persists; rst_i mid-hold -> victim_valid_o=0, lfsr_o=Seed.
